// File: rtl/tm_controller.sv
// Control unit for the 8-cell, 2-bit-symbol Turing machine tape.
// Steps a programmable 8-state x 4-symbol rule table, four cycles per step, until a halt condition.
module tm_controller #(
   parameter int MAX_STEPS = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       clear_on_start,
   input  logic [2:0] init_state,
   input  logic [2:0] start_head,
   input  logic       rule_we,
   input  logic [4:0] rule_addr,
   input  logic [6:0] rule_data,
   input  logic [1:0] tape_out,
   output logic [2:0] tape_head,
   output logic       tape_mode,
   output logic [1:0] tape_in,
   output logic       tape_clr,
   output logic       busy,
   output logic       halted,
   output logic [1:0] halt_cause,
   output logic [2:0] cur_state,
   output logic [7:0] step_count
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] CLEAR  = 3'd1;
   localparam logic [2:0] READ_A = 3'd2;
   localparam logic [2:0] READ_B = 3'd3;
   localparam logic [2:0] WRITE  = 3'd4;
   localparam logic [2:0] MOVE   = 3'd5;
   localparam logic [2:0] HALT   = 3'd6;

   localparam logic [7:0] STEP_LIMIT  = 8'(MAX_STEPS);
   localparam logic [6:0] HALT_ENTRY  = 7'b000_00_11;

   localparam logic [1:0] MV_STAY  = 2'b00;
   localparam logic [1:0] MV_RIGHT = 2'b01;
   localparam logic [1:0] MV_LEFT  = 2'b10;
   localparam logic [1:0] MV_HALT  = 2'b11;

   logic [2:0] fsm_reg;
   logic [2:0] cur_state_reg;
   logic [2:0] head_reg;
   logic [2:0] clr_idx_reg;
   logic [1:0] sym_reg;
   logic [2:0] next_state_reg;
   logic [1:0] move_reg;
   logic [1:0] halt_cause_reg;
   logic [7:0] step_count_reg;
   logic [7:0] step_next;

   logic [6:0]  rule_table [32];
   logic [31:0] entry_we;
   logic [6:0]  rule_sel;
   logic        idle_or_halt;
   logic        edge_fault;

   assign idle_or_halt = (fsm_reg == IDLE) || (fsm_reg == HALT);
   assign rule_sel     = rule_table[{cur_state_reg, sym_reg}];
   assign step_next    = step_count_reg + 8'd1;
   assign edge_fault   = ((move_reg == MV_RIGHT) && (head_reg == 3'd7)) ||
                         ((move_reg == MV_LEFT)  && (head_reg == 3'd0));

   // Table writes are only accepted while no run is in progress.
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_rule_we
         assign entry_we[gi] = rule_we && idle_or_halt && (rule_addr == 5'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < 32; i++) begin
         if (reset)
            rule_table[i] <= HALT_ENTRY;
         else if (entry_we[i])
            rule_table[i] <= rule_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_reg        <= IDLE;
         cur_state_reg  <= 3'd0;
         head_reg       <= 3'd0;
         clr_idx_reg    <= 3'd0;
         sym_reg        <= 2'b00;
         next_state_reg <= 3'd0;
         move_reg       <= MV_STAY;
         halt_cause_reg <= 2'b00;
         step_count_reg <= 8'd0;
      end else begin
         case (fsm_reg)
            IDLE, HALT: begin
               if (start) begin
                  cur_state_reg  <= init_state;
                  head_reg       <= start_head;
                  clr_idx_reg    <= 3'd0;
                  step_count_reg <= 8'd0;
                  halt_cause_reg <= 2'b00;
                  fsm_reg        <= clear_on_start ? CLEAR : READ_A;
               end
            end
            CLEAR: begin
               clr_idx_reg <= clr_idx_reg + 3'd1;
               if (clr_idx_reg == 3'd7)
                  fsm_reg <= READ_A;
            end
            READ_A: fsm_reg <= READ_B;
            READ_B: begin
               sym_reg <= tape_out;
               fsm_reg <= WRITE;
            end
            WRITE: begin
               next_state_reg <= rule_sel[6:4];
               move_reg       <= rule_sel[1:0];
               fsm_reg        <= MOVE;
            end
            MOVE: begin
               cur_state_reg  <= next_state_reg;
               step_count_reg <= step_next;
               if (move_reg == MV_HALT) begin
                  halt_cause_reg <= 2'b01;
                  fsm_reg        <= HALT;
               end else if (edge_fault) begin
                  halt_cause_reg <= 2'b10;
                  fsm_reg        <= HALT;
               end else begin
                  // A legal move is still taken on the step that hits the limit.
                  if (move_reg == MV_RIGHT)
                     head_reg <= head_reg + 3'd1;
                  else if (move_reg == MV_LEFT)
                     head_reg <= head_reg - 3'd1;
                  if (step_next == STEP_LIMIT) begin
                     halt_cause_reg <= 2'b11;
                     fsm_reg        <= HALT;
                  end else begin
                     fsm_reg <= READ_A;
                  end
               end
            end
            default: fsm_reg <= IDLE;
         endcase
      end
   end

   // Write strobes are masked while reset is high so an interrupted write never lands.
   assign tape_mode  = !reset && ((fsm_reg == CLEAR) || (fsm_reg == WRITE));
   assign tape_clr   = !reset && (fsm_reg == CLEAR);
   assign tape_head  = (fsm_reg == CLEAR) ? clr_idx_reg : head_reg;
   assign tape_in    = (fsm_reg == WRITE) ? rule_sel[3:2] : 2'b00;
   assign busy       = (fsm_reg == CLEAR) || (fsm_reg == READ_A) || (fsm_reg == READ_B) ||
                       (fsm_reg == WRITE) || (fsm_reg == MOVE);
   assign halted     = (fsm_reg == HALT);
   assign halt_cause = halt_cause_reg;
   assign cur_state  = cur_state_reg;
   assign step_count = step_count_reg;

endmodule

// File: tb/tb_tm_controller.sv
// Randomized bench for tm_controller: a behavioural tape plus a step-level machine model
// predict the final tape, state, head, step count, halt cause and busy time of each run.
module tb_tm_controller;

   localparam int MAXS = 12;

   logic       clk = 1'b0;
   logic       reset, start, clear_on_start, rule_we;
   logic [2:0] init_state, start_head;
   logic [4:0] rule_addr;
   logic [6:0] rule_data;
   logic [1:0] tape_out;
   logic [2:0] tape_head;
   logic       tape_mode;
   logic [1:0] tape_in;
   logic       tape_clr;
   logic       busy, halted;
   logic [1:0] halt_cause;
   logic [2:0] cur_state;
   logic [7:0] step_count;

   int vectors     = 0;
   int miscompares = 0;

   logic [6:0] tbl [32];
   logic [1:0] tape [8];
   logic [1:0] preload_val [8];
   logic       preload_req = 1'b0;
   int         write_cnt = 0;

   logic [1:0] exp_tape [8];
   logic [2:0] exp_state, exp_head;
   int         exp_steps, exp_cause;

   tm_controller #(.MAX_STEPS(MAXS)) dut (
      .clk(clk), .reset(reset), .start(start), .clear_on_start(clear_on_start),
      .init_state(init_state), .start_head(start_head),
      .rule_we(rule_we), .rule_addr(rule_addr), .rule_data(rule_data),
      .tape_out(tape_out), .tape_head(tape_head), .tape_mode(tape_mode),
      .tape_in(tape_in), .tape_clr(tape_clr), .busy(busy), .halted(halted),
      .halt_cause(halt_cause), .cur_state(cur_state), .step_count(step_count)
   );

   always #5 clk = ~clk;

   // Tape: registered read, write/clear on tape_mode; preload is a bench-only back door.
   always @(posedge clk) begin
      if (preload_req) begin
         for (int i = 0; i < 8; i++) tape[i] <= preload_val[i];
         write_cnt <= 0;
      end else if (tape_mode) begin
         tape[tape_head] <= tape_clr ? 2'b00 : tape_in;
         if (!tape_clr) write_cnt <= write_cnt + 1;
      end else begin
         tape_out <= tape[tape_head];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic prog(input logic [4:0] a, input logic [6:0] d);
      rule_we = 1'b1; rule_addr = a; rule_data = d;
      @(negedge clk);
      rule_we = 1'b0;
      tbl[a] = d;
   endtask

   // Executes the machine step by step on an abstract tape.
   task automatic model(input logic [2:0] s0, input logic [2:0] h0, input logic clr);
      logic [2:0] s, h;
      logic [6:0] r;
      for (int i = 0; i < 8; i++) exp_tape[i] = clr ? 2'b00 : preload_val[i];
      s = s0; h = h0; exp_steps = 0; exp_cause = 0;
      while (exp_cause == 0) begin
         r = tbl[{s, exp_tape[h]}];
         exp_tape[h] = r[3:2];
         s = r[6:4];
         exp_steps++;
         if (r[1:0] == 2'b11) exp_cause = 1;
         else if ((r[1:0] == 2'b01 && h == 3'd7) || (r[1:0] == 2'b10 && h == 3'd0)) exp_cause = 2;
         else begin
            if (r[1:0] == 2'b01) h = h + 3'd1;
            else if (r[1:0] == 2'b10) h = h - 3'd1;
            if (exp_steps == MAXS) exp_cause = 3;
         end
      end
      exp_state = s; exp_head = h;
   endtask

   task automatic preload_tape();
      for (int i = 0; i < 8; i++) preload_val[i] = 2'($urandom_range(0, 3));
      preload_req = 1'b1;
      @(negedge clk);
      preload_req = 1'b0;
   endtask

   task automatic run(input logic [2:0] s0, input logic [2:0] h0, input logic clr, input logic meddle);
      int cyc, busy_n;
      logic [15:0] obs_t, exp_t;
      preload_tape();
      model(s0, h0, clr);
      init_state = s0; start_head = h0; clear_on_start = clr; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      init_state = 3'($urandom); start_head = 3'($urandom); clear_on_start = 1'($urandom);
      cyc = 0; busy_n = 0;
      while (!halted && cyc < 2000) begin
         if (busy) busy_n++;
         if (meddle && cyc == 4) begin
            rule_we = 1'b1; rule_addr = 5'd0; rule_data = 7'b000_01_11;
            start = 1'b1; init_state = 3'd7; start_head = 3'd7;
         end else begin
            rule_we = 1'b0; start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      rule_we = 1'b0; start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         obs_t[2*i +: 2] = tape[i];
         exp_t[2*i +: 2] = exp_tape[i];
      end
      chk("halted",     32'(halted), 32'd1);
      chk("busy_low",   32'(busy), 32'd0);
      chk("halt_cause", 32'(halt_cause), 32'(exp_cause));
      chk("cur_state",  32'(cur_state), 32'(exp_state));
      chk("tape_head",  32'(tape_head), 32'(exp_head));
      chk("step_count", 32'(step_count), 32'(exp_steps));
      chk("busy_cycles", 32'(busy_n), 32'((clr ? 8 : 0) + 4 * exp_steps));
      chk("write_count", 32'(write_cnt), 32'(exp_steps));
      chk("tape",       32'(obs_t), 32'(exp_t));
      chk("mode_halt",  32'(tape_mode), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_head"},  32'(tape_head), 32'd0);
      chk({tag, "_mode"},  32'(tape_mode), 32'd0);
      chk({tag, "_in"},    32'(tape_in), 32'd0);
      chk({tag, "_clr"},   32'(tape_clr), 32'd0);
      chk({tag, "_busy"},  32'(busy), 32'd0);
      chk({tag, "_halt"},  32'(halted), 32'd0);
      chk({tag, "_cause"}, 32'(halt_cause), 32'd0);
      chk({tag, "_state"}, 32'(cur_state), 32'd0);
      chk({tag, "_steps"}, 32'(step_count), 32'd0);
   endtask

   initial begin
      int cyc;
      reset = 1'b1; start = 1'b0; clear_on_start = 1'b0; rule_we = 1'b0;
      init_state = 3'd0; start_head = 3'd0; rule_addr = 5'd0; rule_data = 7'd0;
      for (int i = 0; i < 32; i++) tbl[i] = 7'b000_00_11;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_reset_outputs("reset");

      // Unprogrammed table: single halting step writing 00 at cell 3.
      run(3'd0, 3'd3, 1'b0, 1'b0);

      // Right sweep writing 01 until the right-edge fault.
      prog(5'b000_00, 7'b000_01_01);
      prog(5'b000_01, 7'b000_01_11);
      run(3'd0, 3'd0, 1'b1, 1'b0);

      // Left move from cell 0.
      for (int s = 0; s < 4; s++) prog({3'd2, 2'(s)}, 7'b101_11_10);
      run(3'd2, 3'd0, 1'b1, 1'b0);

      // Stay-in-place loop runs into the step limit.
      prog(5'b000_00, 7'b000_10_00);
      prog(5'b000_10, 7'b000_10_00);
      run(3'd0, 3'd4, 1'b1, 1'b0);

      // Table write and start during a run are dropped; the same write in idle lands.
      run(3'd0, 3'd4, 1'b1, 1'b1);
      prog(5'b000_00, 7'b000_01_11);
      run(3'd0, 3'd4, 1'b1, 1'b0);

      repeat (25) begin
         for (int a = 0; a < 32; a++) prog(5'(a), 7'($urandom));
         run(3'($urandom), 3'($urandom), 1'($urandom), 1'b0);
      end

      // Reset during the write cycle of step 3.
      prog(5'b000_00, 7'b000_10_00);
      prog(5'b000_10, 7'b000_10_00);
      preload_tape();
      init_state = 3'd0; start_head = 3'd2; clear_on_start = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!(tape_mode && write_cnt == 2) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("reach_step3_write", 32'(cyc < 200), 32'd1);
      reset = 1'b1;
      #1;
      chk("mode_during_reset", 32'(tape_mode), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 32; i++) tbl[i] = 7'b000_00_11;
      chk("write_dropped", 32'(write_cnt), 32'd2);
      check_reset_outputs("midrun_reset");
      run(3'd5, 3'd6, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tm_controller.md
# tm_controller

Finite-state control unit for the lab 3 Turing machine. Sits directly upstream of the 8-cell, 2-bit-symbol tape: it drives the tape's head index, read/write mode, write symbol and cell-clear, consumes the tape's read data, and steps a programmable 8-state × 4-symbol transition table until a halt condition. Also provides a load port for the rule table and status outputs for the top level.

## Interface
- MAX_STEPS, 255: step limit before timeout halt; 1..255.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clears controller and rule table.
- start  in  1  one-cycle pulse; begins a run from IDLE or HALT; ignored while busy.
- clear_on_start  in  1  sampled with start; 1 = clear all 8 tape cells before the first step.
- init_state  in  3  machine state at run start; sampled with start.
- start_head  in  3  head position at run start; sampled with start.
- rule_we  in  1  rule-table write enable; honoured only when busy=0.
- rule_addr  in  5  {state[2:0], symbol[1:0]}.
- rule_data  in  7  [6:4] next state, [3:2] symbol to write, [1:0] move (00 stay, 01 right, 10 left, 11 halt).
- tape_out  in  2  tape read data; registered by the tape, valid one cycle after head set with mode 0.
- tape_head  out  3  tape head index.
- tape_mode  out  1  1 = write/clear cycle, 0 = read.
- tape_in  out  2  symbol written when tape_mode=1.
- tape_clr  out  1  with tape_mode=1, clears the cell at tape_head to 00.
- busy  out  1  high in CLEAR, READ_A, READ_B, WRITE, MOVE.
- halted  out  1  high in HALT.
- halt_cause  out  2  00 none, 01 halt rule, 10 edge fault, 11 timeout.
- cur_state  out  3  current machine state.
- step_count  out  8  completed steps in current run.

## Operation
- Controller FSM: IDLE, CLEAR, READ_A, READ_B, WRITE, MOVE, HALT.
- IDLE/HALT + start: latch init_state, start_head; step_count←0, halt_cause←00; go to CLEAR if clear_on_start, else READ_A.
- CLEAR: 8 cycles; tape_head = 0..7, tape_mode=1, tape_clr=1; then tape_head←start_head, go READ_A.
- READ_A: tape_mode=0, head held; tape latches cell.
- READ_B: tape_mode=0; sym←tape_out at end of cycle.
- WRITE: rule←table[{cur_state,sym}]; tape_mode=1, tape_in=rule write symbol, tape_clr=0; rule fields registered.
- MOVE: tape_mode=0; cur_state←next state; step_count+1 (saturating never needed, see timeout); head update; then:
  - move=11 → HALT, cause 01, head unchanged.
  - move=01 at head 7 or move=10 at head 0 → HALT, cause 10, head unchanged (no wrap).
  - step_count reaching MAX_STEPS → HALT, cause 11.
  - priority: halt rule > edge fault > timeout. Otherwise → READ_A.
- Halt-rule step still performs its write and state update.
- Rule table: 32×7 registers; reset fills every entry with 7'b000_00_11 (unprogrammed = halt). Write takes effect next edge; rule_we while busy dropped.
- start while busy ignored; start and rule_we same cycle in IDLE: both honoured, start sees old table entry only if same address read before write (cannot occur: first lookup ≥2 cycles later).

## Timing
- Reset values: tape_head 0, tape_mode 0, tape_in 00, tape_clr 0, busy 0, halted 0, halt_cause 00, cur_state 0, step_count 0, FSM IDLE.
- Reset mid-run: next edge all outputs to reset values; any in-flight tape write is dropped (tape_mode 0 in reset cycle).
- start→first READ_A: 1 cycle (no clear) or 9 cycles (with clear).
- One step = 4 cycles (READ_A, READ_B, WRITE, MOVE); exactly one write cycle per step.
- halted asserts the cycle after final MOVE; outputs hold in HALT until start or reset.

## Test plan
- Reset, no programming, start with init_state 0, head 3 → 1 step, write 00 at cell 3, halted=1, halt_cause 01, step_count 1, busy high exactly 4 cycles.
- Program state 0/sym 00 → {0,01,01}, state 0/sym 01 → {0,01,11}; clear_on_start=1, head 0 → cells 0..7 written 01, edge fault at head 7 after 8 steps, cause 10, tape reads 01 in all cells.
- Rule {0,10,00} (stay, loop) with MAX_STEPS=5 → halt cause 11, step_count 5, cell at head = 10.
- Left move from head 0 → cause 10, head stays 0, cur_state updated.
- rule_we and start asserted mid-run → no table change, run unaffected; same writes in IDLE take effect.
- Assert reset in WRITE of step 3 → tape_mode 0 next edge, all status reset, table restored to halt entries.
